// File: rtl/leaky_relu_derivative_sched_pkg.sv
// Shared definitions for the leaky-ReLU derivative sequencer slice.
//   DATA_W   : width of one Q8.8 value (H, gradient, leak factor)
//   state_t  : sequencer states IDLE -> RUN -> DRAIN -> DONE
//   lane_lsb : bit offset of a lane's slice inside a packed row bus
package leaky_relu_derivative_sched_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic int lane_lsb(input int lane);
    return lane * DATA_W;
  endfunction

endpackage

// File: rtl/leaky_relu_derivative_sched_h_fifo.sv
// lrd_h_fifo: single-lane Q8.8 H-value FIFO with registered head.
//   clk, rst       : clock, asynchronous active-high reset
//   push/push_data : write one entry (accepted when not full, or when a
//                    pop happens in the same cycle)
//   pop            : advance the read pointer; ignored when empty
//   full/empty     : occupancy flags from the current pointers
//   head           : entry captured by the most recent pop; holds otherwise
module lrd_h_fifo
  import leaky_relu_derivative_sched_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic signed [DATA_W-1:0] push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic signed [DATA_W-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic signed [DATA_W-1:0] mem [DEPTH];
  // Extra MSB distinguishes full from empty when the low bits coincide.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // At full, a same-cycle pop frees the slot being overwritten; the read
  // below still sees the old contents because both updates are non-blocking.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      head   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        head   <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/leaky_relu_derivative_sched.sv
// leaky_relu_derivative_sched: sequencer and H buffer for a row of
// leaky-ReLU derivative lanes in the backward-pass vector unit.
//   clk, rst          : clock, asynchronous active-high reset
//   start             : begin a backward pass (accepted only in IDLE)
//   num_rows          : rows per lane for the pass, latched on start
//   leak_factor_in    : Q8.8 leak factor, latched on start -> lane_leak
//   h_wr_en/h_wr_data : push one H row into every lane FIFO
//   grad_valid_in/
//   grad_data_in      : skewed per-lane gradient beats
//   lane_valid/lane_data/lane_h : per-lane child inputs, one cycle after issue
//   lane_leak         : leak factor shared by all children
//   child_valid_out   : per-lane child result strobes, counted for completion
//   busy              : pass in RUN or DRAIN
//   done              : one-cycle completion pulse
//   h_overflow        : sticky, a row push was dropped on a full lane
//   h_underflow       : sticky, a gradient beat found its lane FIFO empty
module leaky_relu_derivative_sched
  import leaky_relu_derivative_sched_pkg::*;
#(
  parameter int LANES = 2,
  parameter int DEPTH = 16,
  parameter int ROW_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ROW_W-1:0]          num_rows,
  input  logic [DATA_W-1:0]         leak_factor_in,
  input  logic                      h_wr_en,
  input  logic [LANES*DATA_W-1:0]   h_wr_data,
  input  logic [LANES-1:0]          grad_valid_in,
  input  logic [LANES*DATA_W-1:0]   grad_data_in,
  output logic [LANES-1:0]          lane_valid,
  output logic [LANES*DATA_W-1:0]   lane_data,
  output logic [LANES*DATA_W-1:0]   lane_h,
  output logic [DATA_W-1:0]         lane_leak,
  input  logic [LANES-1:0]          child_valid_out,
  output logic                      busy,
  output logic                      done,
  output logic                      h_overflow,
  output logic                      h_underflow
);

  state_t           state_q;
  state_t           state_nxt;
  logic [ROW_W-1:0] rows_q;
  logic             start_acc;
  logic             run;
  logic             push_ok;
  logic             ovf_hit;
  logic [LANES-1:0] fifo_full;
  logic [LANES-1:0] fifo_empty;
  logic [LANES-1:0] pop;
  logic [LANES-1:0] blocked;
  logic [LANES-1:0] unf_hit;
  logic [LANES-1:0] issue_done;
  logic [LANES-1:0] out_done;

  assign start_acc = start && (state_q == ST_IDLE);
  assign run       = (state_q == ST_RUN);
  assign busy      = run || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);

  // A full lane only blocks the row if it is not also popping this cycle.
  assign push_ok = h_wr_en && !(|blocked);
  assign ovf_hit = h_wr_en && (|blocked);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [ROW_W-1:0]         issue_cnt;
    logic [ROW_W-1:0]         out_cnt;
    logic [ROW_W-1:0]         out_cnt_nxt;
    logic                     below;
    logic signed [DATA_W-1:0] grad_p0;
    logic                     lane_vld_p1;
    logic signed [DATA_W-1:0] lane_data_p1;

    assign grad_p0       = grad_data_in[lane_lsb(i) +: DATA_W];
    assign below         = (issue_cnt < rows_q);
    assign pop[i]        = run && grad_valid_in[i] && !fifo_empty[i] && below;
    assign unf_hit[i]    = run && grad_valid_in[i] &&  fifo_empty[i] && below;
    assign blocked[i]    = fifo_full[i] && !pop[i];
    assign out_cnt_nxt   = out_cnt + ROW_W'(busy && child_valid_out[i]);
    assign issue_done[i] = (issue_cnt == rows_q);
    // Look-ahead on the output count lets DONE follow the final child strobe
    // directly instead of one cycle later.
    assign out_done[i]   = (out_cnt_nxt == rows_q);

    lrd_h_fifo #(
      .DEPTH(DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push_ok),
      .push_data(h_wr_data[lane_lsb(i) +: DATA_W]),
      .pop      (pop[i]),
      .full     (fifo_full[i]),
      .empty    (fifo_empty[i]),
      .head     (lane_h[lane_lsb(i) +: DATA_W])
    );

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        issue_cnt <= '0;
        out_cnt   <= '0;
      end else if (start_acc) begin
        issue_cnt <= '0;
        out_cnt   <= '0;
      end else begin
        if (pop[i]) begin
          issue_cnt <= issue_cnt + 1'b1;
        end
        out_cnt <= out_cnt_nxt;
      end
    end

    // p0 -> p1: issued beat presented to the child alongside the popped H
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        lane_vld_p1  <= 1'b0;
        lane_data_p1 <= '0;
      end else begin
        lane_vld_p1  <= pop[i];
        lane_data_p1 <= pop[i] ? grad_p0 : '0;
      end
    end

    assign lane_valid[i]                    = lane_vld_p1;
    assign lane_data[lane_lsb(i) +: DATA_W] = lane_data_p1;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_nxt = (num_rows == '0) ? ST_DONE : ST_RUN;
      ST_RUN:   if (&issue_done) state_nxt = ST_DRAIN;
      ST_DRAIN: if (&out_done) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rows_q      <= '0;
      lane_leak   <= '0;
      h_overflow  <= 1'b0;
      h_underflow <= 1'b0;
    end else begin
      state_q <= state_nxt;
      if (start_acc) begin
        rows_q    <= num_rows;
        lane_leak <= leak_factor_in;
      end
      // Accepted start clears the sticky flags; an event in the same cycle
      // still registers.
      h_overflow  <= (start_acc ? 1'b0 : h_overflow)  | ovf_hit;
      h_underflow <= (start_acc ? 1'b0 : h_underflow) | (|unf_hit);
    end
  end

endmodule
